// File: rtl/rx_mac.sv
// XGMII (32-bit) receive MAC: finds Start/SFD/Terminate, strips preamble and
// FCS, delivers the frame on AXI-Stream and flags CRC and length errors.
module rx_mac #(
  parameter int AXIS_DATA_WIDTH  = 32,
  parameter int XGMII_DATA_WIDTH = 32,
  parameter int MIN_FRAME_SIZE   = 64,
  parameter int MAX_FRAME_SIZE   = 1518
) (
  input  logic                            rx_clk,
  input  logic                            rx_rst,
  input  logic [XGMII_DATA_WIDTH-1:0]     in_xgmii_data,
  input  logic [XGMII_DATA_WIDTH/8-1:0]   in_xgmii_ctl,
  input  logic                            in_xgmii_valid,
  output logic [AXIS_DATA_WIDTH-1:0]      out_master_rx_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]    out_master_rx_tkeep,
  output logic                            out_master_rx_tvalid,
  output logic                            out_master_rx_tlast,
  output logic                            out_master_rx_tuser,
  output logic                            out_rx_good_frame,
  output logic                            out_rx_bad_frame
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, FLUSH} state_t;

  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_SIZE);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_FRAME_SIZE);

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) begin
        c = c ^ 32'hEDB88320;
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] d,
                                             input logic [2:0] nbytes);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < nbytes) begin
        c = crc32_byte(c, d[8*i +: 8]);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // The register runs LSB-first; the residue constant is in polynomial (MSB-first) order.
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [2:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {14'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Returns {hit, lane} for a well-formed Terminate word.
  function automatic logic [2:0] term_lane(input logic [3:0] ctl, input logic [31:0] d);
    logic [2:0] r;
    case (ctl)
      4'b1111: r = {d[7:0]   == 8'hFD, 2'd0};
      4'b1110: r = {d[15:8]  == 8'hFD, 2'd1};
      4'b1100: r = {d[23:16] == 8'hFD, 2'd2};
      4'b1000: r = {d[31:24] == 8'hFD, 2'd3};
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] keep_mask(input logic [1:0] k);
    case (k)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] s1_q, s1_d, s2_q, s2_d;
  logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic        emitted_q, emitted_d;
  logic        tail_q, tail_d;
  logic [3:0]  tail_keep_q, tail_keep_d;
  logic        err_q, err_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic        good_q, good_d, bad_q, bad_d;

  logic [2:0]  term_s;
  logic [1:0]  k_s;
  logic        term_hit_s, start_s, err_s;
  logic [31:0] crc_fin_s;
  logic [15:0] cnt_fin_s;

  // Terminate decode and end-of-frame check, valid whenever the word is a Terminate.
  always_comb begin
    term_s     = term_lane(in_xgmii_ctl, in_xgmii_data);
    term_hit_s = term_s[2];
    k_s        = term_s[1:0];
    start_s    = (in_xgmii_ctl == 4'b0001) && (in_xgmii_data[7:0] == 8'hFB);
    crc_fin_s  = crc32_word(crc_q, in_xgmii_data, {1'b0, k_s});
    cnt_fin_s  = sat_add(cnt_q, {1'b0, k_s});
    err_s      = (bitrev32(crc_fin_s) != CRC_RESIDUE) || (cnt_fin_s < MIN_LEN) ||
                 (cnt_fin_s > MAX_LEN);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    s1_d        = s1_q;
    s1_vld_d    = s1_vld_q;
    s2_d        = s2_q;
    s2_vld_d    = s2_vld_q;
    emitted_d   = emitted_q;
    tail_d      = tail_q;
    tail_keep_d = tail_keep_q;
    err_d       = err_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    if (in_xgmii_valid) begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_d = PREAMBLE;
          end else begin
            state_d = IDLE;
          end
        end
        PREAMBLE: begin
          if ((in_xgmii_ctl == 4'b0000) && (in_xgmii_data == 32'hD5555555)) begin
            state_d   = DATA;
            crc_d     = 32'hFFFFFFFF;
            cnt_d     = 16'd0;
            s1_vld_d  = 1'b0;
            s2_vld_d  = 1'b0;
            emitted_d = 1'b0;
            tail_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: begin
          if (in_xgmii_ctl == 4'b0000) begin
            crc_d    = crc32_word(crc_q, in_xgmii_data, 3'd4);
            cnt_d    = sat_add(cnt_q, 3'd4);
            s1_d     = s2_q;
            s1_vld_d = s2_vld_q;
            s2_d     = in_xgmii_data;
            s2_vld_d = 1'b1;
            if (s1_vld_q) begin
              tvalid_d  = 1'b1;
              tdata_d   = s1_q;
              tkeep_d   = 4'b1111;
              emitted_d = 1'b1;
            end else begin
              emitted_d = emitted_q;
            end
          end else if (term_hit_s) begin
            err_d       = err_s;
            tail_keep_d = keep_mask(k_s);
            if (s1_vld_q) begin
              tvalid_d = 1'b1;
              tdata_d  = s1_q;
              tkeep_d  = 4'b1111;
              state_d  = FLUSH;
              if (k_s == 2'd0) begin
                tlast_d = 1'b1;
                tuser_d = err_s;
                good_d  = ~err_s;
                bad_d   = err_s;
                tail_d  = 1'b0;
              end else begin
                tail_d  = 1'b1;
              end
            end else begin
              bad_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            if (emitted_q) begin
              tvalid_d = 1'b1;
              tdata_d  = s1_q;
              tkeep_d  = 4'b1111;
              tlast_d  = 1'b1;
              tuser_d  = 1'b1;
            end else begin
              tvalid_d = 1'b0;
            end
            bad_d   = 1'b1;
            state_d = IDLE;
          end
        end
        FLUSH: begin
          if (tail_q) begin
            tvalid_d = 1'b1;
            tdata_d  = s2_q;
            tkeep_d  = tail_keep_q;
            tlast_d  = 1'b1;
            tuser_d  = err_q;
            good_d   = ~err_q;
            bad_d    = err_q;
            tail_d   = 1'b0;
          end else begin
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q     <= IDLE;
      crc_q       <= 32'hFFFFFFFF;
      cnt_q       <= 16'd0;
      s1_q        <= 32'd0;
      s1_vld_q    <= 1'b0;
      s2_q        <= 32'd0;
      s2_vld_q    <= 1'b0;
      emitted_q   <= 1'b0;
      tail_q      <= 1'b0;
      tail_keep_q <= 4'd0;
      err_q       <= 1'b0;
      tdata_q     <= 32'd0;
      tkeep_q     <= 4'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      s1_q        <= s1_d;
      s1_vld_q    <= s1_vld_d;
      s2_q        <= s2_d;
      s2_vld_q    <= s2_vld_d;
      emitted_q   <= emitted_d;
      tail_q      <= tail_d;
      tail_keep_q <= tail_keep_d;
      err_q       <= err_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign out_master_rx_tdata  = tdata_q;
  assign out_master_rx_tkeep  = tkeep_q;
  assign out_master_rx_tvalid = tvalid_q;
  assign out_master_rx_tlast  = tlast_q;
  assign out_master_rx_tuser  = tuser_q;
  assign out_rx_good_frame    = good_q;
  assign out_rx_bad_frame     = bad_q;

endmodule

// File: tb/tb_rx_mac.sv
// Directed bench for rx_mac: a table of frames with hand-computed outcomes,
// plus hand-written reset-in-frame and reset-state sequences.
module tb_rx_mac;

  logic        clk = 1'b0;
  logic        rx_rst;
  logic [31:0] xd;
  logic [3:0]  xc;
  logic        xv;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tvalid, tlast, tuser, good, bad;

  always #5 clk = ~clk;

  rx_mac dut (
    .rx_clk(clk), .rx_rst(rx_rst),
    .in_xgmii_data(xd), .in_xgmii_ctl(xc), .in_xgmii_valid(xv),
    .out_master_rx_tdata(tdata), .out_master_rx_tkeep(tkeep),
    .out_master_rx_tvalid(tvalid), .out_master_rx_tlast(tlast),
    .out_master_rx_tuser(tuser), .out_rx_good_frame(good), .out_rx_bad_frame(bad)
  );

  typedef struct {
    int         len;
    int         flip;
    int         abort_w;
    int         gap_w;
    int         exp_beats;
    logic [3:0] exp_keep;
    logic       exp_tuser;
    int         exp_good;
    int         exp_bad;
    int         exp_bytes;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         beats, tlast_cnt, good_cnt, bad_cnt, misalign, bad_keep, first_cyc, d2_cyc;
  logic [3:0] last_keep;
  logic       last_tuser;
  logic [7:0] rx_bytes[$];
  logic [7:0] fb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tvalid) begin
      if (beats == 0) first_cyc = cyc;
      beats++;
      if (!(tkeep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) bad_keep++;
      for (int i = 0; i < 4; i++) if (tkeep[i]) rx_bytes.push_back(tdata[8*i +: 8]);
      if (tlast) begin
        tlast_cnt++;
        last_keep  = tkeep;
        last_tuser = tuser;
      end
    end
    if (good) good_cnt++;
    if (bad) bad_cnt++;
    if ((good || bad) && tvalid && !tlast) misalign++;
    if (tvalid && tlast && !(good || bad)) misalign++;
    if (good && bad) misalign++;
  end

  task automatic clear_mon();
    beats = 0; tlast_cnt = 0; good_cnt = 0; bad_cnt = 0; misalign = 0; bad_keep = 0;
    first_cyc = -1; d2_cyc = -1; last_keep = 4'd0; last_tuser = 1'b0;
    rx_bytes.delete();
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] d);
    @(negedge clk);
    xv = v; xc = c; xd = d;
  endtask

  // Standard Ethernet FCS over the first n bytes of fb.
  function automatic logic [31:0] eth_fcs(input int n);
    logic [31:0] crc;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      crc = crc ^ {24'd0, fb[i]};
      for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    return ~crc;
  endfunction

  task automatic build_frame(input int len, input int flip);
    logic [31:0] fcs;
    fb.delete();
    for (int i = 0; i < len - 4; i++) fb.push_back(8'((i * 37 + len) & 255));
    fcs = eth_fcs(len - 4);
    for (int i = 0; i < 4; i++) fb.push_back(fcs[8*i +: 8]);
    if (flip >= 0) fb[flip] = fb[flip] ^ 8'h01;
  endtask

  function automatic logic [31:0] word_at(input int w);
    return {fb[4*w+3], fb[4*w+2], fb[4*w+1], fb[4*w]};
  endfunction

  task automatic send_frame(input vec_t v);
    int          nfull, k;
    logic [31:0] tw;
    logic [3:0]  tc;
    bit          aborted;
    build_frame(v.len, v.flip);
    nfull   = v.len / 4;
    k       = v.len % 4;
    aborted = 1'b0;
    drive(1'b1, 4'b0001, 32'h555555FB);
    drive(1'b1, 4'b0000, 32'hD5555555);
    for (int w = 0; w < nfull && !aborted; w++) begin
      if (w == v.gap_w) repeat (3) drive(1'b0, 4'b1111, 32'hDEADBEEF);
      if (w == v.abort_w) begin
        drive(1'b1, 4'b0001, {fb[4*w+3], fb[4*w+2], fb[4*w+1], 8'hFE});
        aborted = 1'b1;
      end else begin
        drive(1'b1, 4'b0000, word_at(w));
        if (w == 2) d2_cyc = cyc;
      end
    end
    if (!aborted) begin
      tw = 32'h07070707;
      tc = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (i < k) tw[8*i +: 8] = fb[4*nfull+i];
        else tc[i] = 1'b1;
      end
      tw[8*k +: 8] = 8'hFD;
      drive(1'b1, tc, tw);
    end
    repeat (4) drive(1'b1, 4'b1111, 32'h07070707);
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    int mism;
    check({tag, "_beats"}, 64'(beats), 64'(v.exp_beats));
    check({tag, "_tlast_count"}, 64'(tlast_cnt), 64'(v.exp_beats > 0 ? 1 : 0));
    check({tag, "_good_pulses"}, 64'(good_cnt), 64'(v.exp_good));
    check({tag, "_bad_pulses"}, 64'(bad_cnt), 64'(v.exp_bad));
    check({tag, "_pulse_align"}, 64'(misalign), 64'd0);
    check({tag, "_tkeep_legal"}, 64'(bad_keep), 64'd0);
    check({tag, "_byte_count"}, 64'(rx_bytes.size()), 64'(v.exp_bytes));
    mism = 0;
    for (int i = 0; i < rx_bytes.size() && i < v.exp_bytes; i++)
      if (rx_bytes[i] !== fb[i]) mism++;
    check({tag, "_byte_mismatches"}, 64'(mism), 64'd0);
    if (v.exp_beats > 0) begin
      check({tag, "_last_tkeep"}, 64'(last_keep), 64'(v.exp_keep));
      check({tag, "_tuser"}, 64'(last_tuser), 64'(v.exp_tuser));
      check({tag, "_latency"}, 64'(first_cyc), 64'(d2_cyc + 1));
    end
  endtask

  vec_t vecs[12];

  initial begin
    //          len  flip abort gap beats keep     tuser good bad bytes
    vecs[0]  = '{64,   -1, -1,  -1, 15,  4'b1111, 1'b0, 1, 0, 60};
    vecs[1]  = '{65,   -1, -1,  -1, 16,  4'b0001, 1'b0, 1, 0, 61};
    vecs[2]  = '{67,   -1, -1,  -1, 16,  4'b0111, 1'b0, 1, 0, 63};
    vecs[3]  = '{64,   20, -1,  -1, 15,  4'b1111, 1'b1, 0, 1, 60};
    vecs[4]  = '{60,   -1, -1,  -1, 14,  4'b1111, 1'b1, 0, 1, 56};
    vecs[5]  = '{7,    -1, -1,  -1, 0,   4'b0000, 1'b0, 0, 1, 0};
    vecs[6]  = '{1518, -1, -1,  -1, 379, 4'b0011, 1'b0, 1, 0, 1514};
    vecs[7]  = '{1519, -1, -1,  -1, 379, 4'b0111, 1'b1, 0, 1, 1515};
    vecs[8]  = '{1522, -1, -1,  -1, 380, 4'b0011, 1'b1, 0, 1, 1518};
    vecs[9]  = '{64,   -1, 5,   -1, 4,   4'b1111, 1'b1, 0, 1, 16};
    vecs[10] = '{64,   -1, -1,  -1, 15,  4'b1111, 1'b0, 1, 0, 60};
    vecs[11] = '{64,   -1, -1,  8,  15,  4'b1111, 1'b0, 1, 0, 60};

    rx_rst = 1'b1; xv = 1'b0; xc = 4'b0000; xd = 32'd0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({tdata, tkeep, tvalid, tlast, tuser, good, bad}), 64'd0);
    @(negedge clk);
    rx_rst = 1'b0;
    repeat (2) drive(1'b1, 4'b1111, 32'h07070707);

    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      clear_mon();
      send_frame(vecs[i]);
      check_frame($sformatf("vec%0d_len%0d", i, vecs[i].len), vecs[i]);
    end

    // Reset in the middle of a frame: no termination, outputs cleared, next frame clean.
    @(posedge clk);
    #1;
    clear_mon();
    build_frame(64, -1);
    drive(1'b1, 4'b0001, 32'h555555FB);
    drive(1'b1, 4'b0000, 32'hD5555555);
    for (int w = 0; w < 10; w++) drive(1'b1, 4'b0000, word_at(w));
    @(negedge clk);
    rx_rst = 1'b1; xv = 1'b1; xc = 4'b1111; xd = 32'h07070707;
    @(posedge clk);
    #1;
    check("midreset_outputs", 64'({tdata, tkeep, tvalid, tlast, tuser, good, bad}), 64'd0);
    @(negedge clk);
    rx_rst = 1'b0;
    repeat (4) drive(1'b1, 4'b1111, 32'h07070707);
    @(posedge clk);
    #1;
    check("midreset_beats", 64'(beats), 64'd8);
    check("midreset_no_tlast", 64'(tlast_cnt), 64'd0);
    check("midreset_no_pulse", 64'(good_cnt + bad_cnt), 64'd0);
    clear_mon();
    send_frame(vecs[0]);
    check_frame("after_reset", vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
